// File: rtl/convolve_seq.sv
// convolve_seq: sequential 3x3 convolution. One window is accepted in IDLE,
// nine taps are multiply-accumulated one per cycle through a single shared
// multiplier in MAC, and the 12.4 result is held in DONE until the sink
// takes it. Coefficients are signed 4.4 and programmable only while idle.
module convolve_seq #(
  parameter int unsigned SAT_EN = 1,
  parameter int unsigned ACC_W  = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] in_window,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [7:0]  coef_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Identity kernel: only the centre tap (tap 4) is 1.0 in 4.4 format.
  localparam logic [71:0] COEF_IDENT = {32'h0000_0000, 8'h10, 32'h0000_0000};

  // Reduce an accumulator value to 16 bits; returns {sat_flag, data}.
  // The value fits in 16 bits iff bits [ACC_W-1:15] are all equal.
  function automatic logic [16:0] reduce16(input logic [ACC_W-1:0] sum,
                                           input logic             sat_en);
    logic over_hi;
    logic over_lo;
    over_hi = ~sum[ACC_W-1] & (|sum[ACC_W-2:15]);
    over_lo =  sum[ACC_W-1] & ~(&sum[ACC_W-2:15]);
    if (sat_en) begin
      if (over_hi) begin
        reduce16 = {1'b1, 16'h7FFF};
      end else if (over_lo) begin
        reduce16 = {1'b1, 16'h8000};
      end else begin
        reduce16 = {1'b0, sum[15:0]};
      end
    end else begin
      reduce16 = {over_hi | over_lo, sum[15:0]};
    end
  endfunction

  state_e            state_q;
  logic [3:0]        tap_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [71:0]       win_q;
  logic [71:0]       coef_q;   // programmable coefficient bank
  logic [71:0]       snap_q;   // bank copy frozen at accept for the running window
  logic              out_valid_q;
  logic [15:0]       out_data_q;
  logic              out_sat_q;

  logic [6:0]        tap_ofs_s;
  logic [7:0]        pix_s;
  logic [7:0]        coef_s;
  logic [16:0]       prod_s;
  logic [16:0]       result_s;
  logic              coef_wr_s;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Shared multiplier and accumulator next value for the current tap.
  always_comb begin
    tap_ofs_s = {tap_q[3:0], 3'b000};
    pix_s     = win_q[tap_ofs_s +: 8];
    coef_s    = snap_q[tap_ofs_s +: 8];
    // Unsigned pixel zero-extended times signed coefficient; |product| < 2^16.
    prod_s    = $signed({9'b0_0000_0000, pix_s}) * $signed({{9{coef_s[7]}}, coef_s});
    acc_d     = acc_q + {{(ACC_W-17){prod_s[16]}}, prod_s};
    result_s  = reduce16(acc_d, (SAT_EN != 32'd0));
    coef_wr_s = coef_we && (state_q == IDLE) && (coef_addr <= 4'd8);
  end

  // Control FSM, datapath registers and coefficient bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tap_q       <= 4'd0;
      acc_q       <= '0;
      win_q       <= 72'd0;
      coef_q      <= COEF_IDENT;
      snap_q      <= COEF_IDENT;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_sat_q   <= 1'b0;
    end else begin
      // The snapshot below uses the pre-write bank, so a same-edge write
      // lands for the next window only.
      if (coef_wr_s) begin
        coef_q[{coef_addr, 3'b000} +: 8] <= coef_data;
      end else begin
        coef_q <= coef_q;
      end

      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            win_q   <= in_window;
            snap_q  <= coef_q;
            acc_q   <= '0;
            tap_q   <= 4'd0;
            state_q <= MAC;
          end else begin
            state_q <= IDLE;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (tap_q == 4'd8) begin
            tap_q       <= 4'd0;
            out_valid_q <= 1'b1;
            out_data_q  <= result_s[15:0];
            out_sat_q   <= result_s[16];
            state_q     <= DONE;
          end else begin
            tap_q   <= tap_q + 4'd1;
            state_q <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          tap_q       <= 4'd0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convolve_seq.sv
// Directed bench for convolve_seq. Two instances run in lockstep on the same
// stimulus: one saturating (ACC_W 20) and one wrapping (ACC_W 24).
module tb_convolve_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [71:0] in_window;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [15:0] out_data_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int stray;

  convolve_seq #(.SAT_EN(1), .ACC_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_window(in_window), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_sat(out_sat_a), .busy(busy_a)
  );

  convolve_seq #(.SAT_EN(0), .ACC_W(24)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_window(in_window), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mkwin(input logic [7:0] ctr, input logic [7:0] oth);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) begin
      w[8*k +: 8] = (k == 4) ? ctr : oth;
    end
    return w;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic start(input logic [71:0] w, input logic we, input logic [3:0] a,
                       input logic [7:0] d);
    in_window = w; in_valid = 1'b1;
    coef_we = we; coef_addr = a; coef_data = d;
    chk("ready_before_accept", {31'd0, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    chk("busy_after_accept", {31'd0, busy_a}, 32'd1);
  endtask

  task automatic wait_result(input logic [15:0] exp_a, input logic sat_a,
                             input logic [15:0] exp_b, input logic sat_b,
                             input logic mac_we, input logic [3:0] a, input logic [7:0] d);
    for (int e = 1; e <= 9; e++) begin
      if (e == 3 && mac_we) begin
        coef_we = 1'b1; coef_addr = a; coef_data = d;
      end
      @(posedge clk); #1;
      coef_we = 1'b0;
      if (e == 8) chk("valid_low_edge8", {31'd0, out_valid_a}, 32'd0);
    end
    chk("valid_high_edge9", {31'd0, out_valid_a}, 32'd1);
    chk("valid_high_edge9_w", {31'd0, out_valid_b}, 32'd1);
    chk("data_sat", {16'd0, out_data_a}, {16'd0, exp_a});
    chk("flag_sat", {31'd0, out_sat_a}, {31'd0, sat_a});
    chk("data_wrap", {16'd0, out_data_b}, {16'd0, exp_b});
    chk("flag_wrap", {31'd0, out_sat_b}, {31'd0, sat_b});
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_busy", {31'd0, busy_a}, 32'd0);
    chk("idle_valid", {31'd0, out_valid_a}, 32'd0);
    chk("idle_ready", {31'd0, in_ready_a}, 32'd1);
    chk("idle_valid_w", {31'd0, out_valid_b}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid_a}, 32'd0);
    chk({tag, "_data"},  {16'd0, out_data_a}, 32'd0);
    chk({tag, "_sat"},   {31'd0, out_sat_a}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_a}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready_a}, 32'd1);
    chk({tag, "_data_w"}, {16'd0, out_data_b}, 32'd0);
    chk({tag, "_busy_w"}, {31'd0, busy_b}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_window = 72'd0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_data = 8'd0; out_ready = 1'b0;
    #3;
    chk_reset_state("por");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Identity kernel, centre 200: 200*16 = 3200 = 0x0C80.
    start(mkwin(8'd200, 8'd7), 1'b0, 4'd0, 8'd0);
    wait_result(16'h0C80, 1'b0, 16'h0C80, 1'b0, 1'b0, 4'd0, 8'd0);

    // Backpressure: hold the result 5 cycles with a competing window offered.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_window = mkwin(8'd1, 8'd1);
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, out_valid_a}, 32'd1);
      chk("bp_data", {16'd0, out_data_a}, 32'h0000_0C80);
      chk("bp_ready", {31'd0, in_ready_a}, 32'd0);
    end
    in_valid = 1'b0;
    handshake();

    // All coefficients 1.0, pixels 255: 9*255*16 = 36720 = 0x8F70.
    for (int t = 0; t < 9; t++) write_coef(t[3:0], 8'h10);
    start(mkwin(8'd255, 8'd255), 1'b0, 4'd0, 8'd0);
    wait_result(16'h7FFF, 1'b1, 16'h8F70, 1'b1, 1'b0, 4'd0, 8'd0);
    handshake();

    // All coefficients -8.0, pixels 255: -293760, low 16 bits 0x8480.
    for (int t = 0; t < 9; t++) write_coef(t[3:0], 8'h80);
    start(mkwin(8'd255, 8'd255), 1'b0, 4'd0, 8'd0);
    wait_result(16'h8000, 1'b1, 16'h8480, 1'b1, 1'b0, 4'd0, 8'd0);
    handshake();

    // Reset in the middle of MAC: outputs clear at once, no late out_valid.
    start(mkwin(8'd200, 8'd7), 1'b0, 4'd0, 8'd0);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk_reset_state("midmac");
    @(negedge clk); reset_n = 1'b1;
    stray = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b) stray++;
    end
    chk("no_stray_valid", stray, 32'd0);
    start(mkwin(8'd200, 8'd7), 1'b0, 4'd0, 8'd0);
    wait_result(16'h0C80, 1'b0, 16'h0C80, 1'b0, 1'b0, 4'd0, 8'd0);
    handshake();

    // Out-of-range address is ignored (12 aliases tap 4 in the low bits).
    write_coef(4'd12, 8'h7F);
    start(mkwin(8'd200, 8'd7), 1'b0, 4'd0, 8'd0);
    wait_result(16'h0C80, 1'b0, 16'h0C80, 1'b0, 1'b0, 4'd0, 8'd0);
    handshake();

    // Write tap 0 on the accept edge (old value used), write tap 4 in MAC (ignored).
    start(mkwin(8'd200, 8'd7), 1'b1, 4'd0, 8'h10);
    wait_result(16'h0C80, 1'b0, 16'h0C80, 1'b0, 1'b1, 4'd4, 8'h00);
    handshake();
    // Next window sees tap 0 = 1.0: 3200 + 7*16 = 3312 = 0x0CF0.
    start(mkwin(8'd200, 8'd7), 1'b0, 4'd0, 8'd0);
    wait_result(16'h0CF0, 1'b0, 16'h0CF0, 1'b0, 1'b0, 4'd0, 8'd0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/convolve_seq.md
CONVOLVE_SEQ -- requirements
Module: convolve_seq

Interface
REQ-001 SHALL have parameter SAT_EN, default 1; 1 = saturate the result to 16 bits, 0 = wrap it.
REQ-002 SHALL have parameter ACC_W, default 20; accumulator width in bits, legal range 20..24.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit; pixel window offered.
REQ-006 SHALL have port in_ready, output, 1 bit; window accepted when in_valid & in_ready.
REQ-007 SHALL have port in_window, input, 72 bits; nine unsigned 8-bit pixels, tap k at bits [8k+7:8k], row-major 3x3.
REQ-008 SHALL have port coef_we, input, 1 bit; coefficient write strobe.
REQ-009 SHALL have port coef_addr, input, 4 bits; tap index 0..8.
REQ-010 SHALL have port coef_data, input, 8 bits; signed 4.4 coefficient.
REQ-011 SHALL have port out_valid, output, 1 bit; result available.
REQ-012 SHALL have port out_ready, input, 1 bit; sink accepts the result when out_valid & out_ready.
REQ-013 SHALL have port out_data, output, 16 bits; signed 12.4 convolution sum.
REQ-014 SHALL have port out_sat, output, 1 bit; the sum was clamped (SAT_EN=1) or overflowed 16 bits (SAT_EN=0).
REQ-015 SHALL have port busy, output, 1 bit; high whenever state != IDLE.

Function
REQ-016 SHALL implement three states: IDLE, MAC, DONE.
REQ-017 IDLE SHALL drive in_ready=1 and out_valid=0.
REQ-018 IDLE: on in_valid, SHALL latch in_window, clear the accumulator, set tap=0 and go to MAC.
REQ-019 MAC SHALL add one product per cycle for tap 0..8, using a single shared 8u x 4.4s multiplier (unsigned pixel zero-extended, 12.4 product).
REQ-020 MAC SHALL leave for DONE on the edge that accumulates tap 8, registering out_data and out_sat on that same edge.
REQ-021 out_valid SHALL rise exactly 9 edges after the accept edge.
REQ-022 DONE SHALL hold out_valid=1 with out_data and out_sat stable, and SHALL return to IDLE on out_valid & out_ready.
REQ-023 Minimum accept-to-accept spacing SHALL be 11 cycles; windows are never overlapped.
REQ-024 in_ready SHALL be 0 in MAC and DONE; in_valid SHALL be ignored there.
REQ-025 Each product SHALL be sign-extended to ACC_W bits before accumulation; the worst case (+/-293760) SHALL never overflow the accumulator.
REQ-026 With SAT_EN=1: sum > 32767 SHALL give 0x7FFF with out_sat=1; sum < -32768 SHALL give 0x8000 with out_sat=1; otherwise the exact sum with out_sat=0.
REQ-027 With SAT_EN=0: out_data SHALL be sum[15:0], and out_sat SHALL be 1 iff sum lies outside [-32768, 32767].
REQ-028 A coefficient write SHALL take effect on the edge only in IDLE with coef_addr <= 8.
REQ-029 Coefficient writes with coef_addr 9..15, or issued in MAC/DONE, SHALL be ignored.
REQ-030 When a write and an accept occur on the same IDLE edge, the write SHALL land and the accepted window SHALL use the old coefficient.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, tap 0, accumulator 0, out_valid 0, out_data 0, out_sat 0, busy 0 and in_ready 1 (combinational from IDLE).
REQ-032 reset_n low SHALL immediately set coefficients to identity: tap 4 = 0x10, all other taps 0x00.
REQ-033 Reset asserted mid-MAC or mid-DONE SHALL discard the in-flight result; no out_valid pulse SHALL follow.

Verification
REQ-034 Identity with no writes: window center pixel 200, others 7 -> out_data 0x0C80, out_sat 0, out_valid exactly 9 edges after accept.
REQ-035 All coefs 0x10, all pixels 255: with SAT_EN=1 -> 0x7FFF, out_sat 1; with SAT_EN=0 -> 0x8F70, out_sat 1.
REQ-036 All coefs 0x80, all pixels 255 (sum -293760) -> 0x8000, out_sat 1.
REQ-037 Backpressure: out_ready low 5 cycles in DONE -> out_data stable, in_ready 0, a concurrent in_valid is not accepted, IDLE follows the handshake edge.
REQ-038 Coef write to tap 0 during MAC -> ignored, result unchanged; coef_addr 12 in IDLE -> ignored; reset at MAC tap 4 -> outputs 0 and identity coefficients restored.
